// File: rtl/serial_out_sequencer_pkg.sv
// Shared types for the serial output sequencer: FSM states, idle-mode
// encodings shared with the serial stage, and internal counter widths.
package serial_out_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_BUSY = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    IDLE_HIGH   = 2'd0,
    IDLE_LOW    = 2'd1,
    IDLE_KEEP   = 2'd2,
    IDLE_REPEAT = 2'd3
  } idle_mode_e;

  localparam int IDLE_W = 2;
  localparam int GAP_W  = 16;

endpackage

// File: rtl/serial_out_sequencer_fifo.sv
// Synchronous FIFO with registered full/empty flags and a flush that
// discards all entries and suppresses any push or pop in the same cycle.
module serial_out_sequencer_fifo #(
  parameter int WIDTH    = 19,
  parameter int ADDR_BIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic             flush,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << ADDR_BIT;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [ADDR_BIT-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BIT-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BIT:0]   count_q, count_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                do_push, do_pop;

  assign do_push = wr_en && !full_q && !flush;
  assign do_pop  = rd_en && !empty_q && !flush;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + ADDR_BIT'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_BIT'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (ADDR_BIT+1)'(1);
        2'b01:   count_d = count_q - (ADDR_BIT+1)'(1);
        default: count_d = count_q;
      endcase
    end
    full_d  = (count_d == (ADDR_BIT+1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  // NOTE: non-blocking assignments for all flops so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone
  // decide which entries are valid, so clearing it would only add logic.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/serial_out_sequencer.sv
// Feeds buffered words one at a time to the serial output stage: load, start
// pulse, wait for done, optional inter-word gap; abort stops and flushes.
module serial_out_sequencer
  import serial_out_sequencer_pkg::*;
#(
  parameter int DATA_BIT   = 16,
  parameter int ADDR_BIT   = 3,
  parameter int GAP_CYCLES = 4,
  parameter int CNT_BIT    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_wr_en,
  input  logic [DATA_BIT-1:0] i_wr_data,
  input  logic                i_wr_sel,
  input  logic [IDLE_W-1:0]   i_wr_idle,
  input  logic                i_abort,
  input  logic                i_done_tick,
  output logic                o_start,
  output logic                o_stop,
  output logic [DATA_BIT-1:0] o_data,
  output logic                o_sel_freq,
  output logic [IDLE_W-1:0]   o_idle_mode,
  output logic                o_full,
  output logic                o_empty,
  output logic                o_overflow,
  output logic                o_busy,
  output logic [CNT_BIT-1:0]  o_word_cnt
);

  localparam int ENTRY_W = DATA_BIT + 1 + IDLE_W;

  state_e              state_q, state_d;
  logic [DATA_BIT-1:0] data_q, data_d;
  logic                sel_q, sel_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [CNT_BIT-1:0]  cnt_q, cnt_d;
  logic                stop_q, stop_d;
  logic                ovf_q, ovf_d;

  logic                fifo_pop;
  logic                fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]  fifo_rd_data;

  serial_out_sequencer_fifo #(
    .WIDTH    (ENTRY_W),
    .ADDR_BIT (ADDR_BIT)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (i_wr_en),
    .wr_data ({i_wr_data, i_wr_sel, i_wr_idle}),
    .rd_en   (fifo_pop),
    .flush   (i_abort),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    sel_d    = sel_q;
    idle_d   = idle_q;
    gap_d    = gap_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    stop_d   = i_abort;
    ovf_d    = i_wr_en && (fifo_full || i_abort);

    // Abort overrides everything: no pop, no count, held outputs untouched.
    if (i_abort) begin
      state_d = ST_IDLE;
      gap_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            fifo_pop                 = 1'b1;
            {data_d, sel_d, idle_d}  = fifo_rd_data;
            state_d                  = ST_LOAD;
          end
        end
        ST_LOAD: state_d = ST_BUSY;
        ST_BUSY: begin
          if (i_done_tick) begin
            cnt_d = cnt_q + CNT_BIT'(1);
            if (GAP_CYCLES == 0) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_GAP;
              gap_d   = GAP_W'(GAP_CYCLES - 1);
            end
          end
        end
        ST_GAP: begin
          if (gap_q == '0) state_d = ST_IDLE;
          else             gap_d   = gap_q - GAP_W'(1);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      sel_q   <= 1'b0;
      idle_q  <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      idle_q  <= idle_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_start     = (state_q == ST_LOAD);
  assign o_stop      = stop_q;
  assign o_data      = data_q;
  assign o_sel_freq  = sel_q;
  assign o_idle_mode = idle_q;
  assign o_full      = fifo_full;
  assign o_empty     = fifo_empty;
  assign o_overflow  = ovf_q;
  assign o_busy      = (state_q != ST_IDLE) || !fifo_empty;
  assign o_word_cnt  = cnt_q;

endmodule

// File: tb/tb_serial_out_sequencer.sv
// Scoreboard bench for serial_out_sequencer: directed scenarios plus random
// traffic, checked against a word-level queue model of the feeder.
module tb_serial_out_sequencer;

  localparam int DATA_BIT   = 16;
  localparam int ADDR_BIT   = 3;
  localparam int GAP_CYCLES = 4;
  localparam int CNT_BIT    = 16;
  localparam int DEPTH      = 8;

  typedef struct {
    logic [15:0] data;
    logic        sel;
    logic [1:0]  idle;
  } word_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_wr_en = 1'b0;
  logic [15:0] i_wr_data = '0;
  logic        i_wr_sel = 1'b0;
  logic [1:0]  i_wr_idle = '0;
  logic        i_abort = 1'b0;
  logic        resp_done = 1'b0;
  logic        man_done = 1'b0;

  logic        o_start, o_stop, o_sel_freq, o_full, o_empty, o_overflow, o_busy;
  logic [15:0] o_data, o_word_cnt;
  logic [1:0]  o_idle_mode;

  serial_out_sequencer #(
    .DATA_BIT   (DATA_BIT),
    .ADDR_BIT   (ADDR_BIT),
    .GAP_CYCLES (GAP_CYCLES),
    .CNT_BIT    (CNT_BIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_wr_en     (i_wr_en),
    .i_wr_data   (i_wr_data),
    .i_wr_sel    (i_wr_sel),
    .i_wr_idle   (i_wr_idle),
    .i_abort     (i_abort),
    .i_done_tick (resp_done | man_done),
    .o_start     (o_start),
    .o_stop      (o_stop),
    .o_data      (o_data),
    .o_sel_freq  (o_sel_freq),
    .o_idle_mode (o_idle_mode),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .o_overflow  (o_overflow),
    .o_busy      (o_busy),
    .o_word_cnt  (o_word_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: words waiting (queue), word in flight, gap remaining.
  word_t exp_q[$];
  int    exp_cnt    = 0;
  bit    in_flight  = 0;
  bit    start_pend = 0;
  int    gap_left   = 0;
  bit    exp_stop   = 0;
  bit    exp_ovf    = 0;
  int    cyc        = 0;
  bit    checking   = 0;

  int          n_starts = 0;
  int          last_start_cyc = 0;
  int          start_cycs[$];
  logic [15:0] last_data = '0;

  bit resp_en    = 0;
  bit resp_rand  = 0;
  int resp_delay = 3;
  int resp_cnt   = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      exp_q.delete();
      exp_cnt    = 0;
      in_flight  = 0;
      start_pend = 0;
      gap_left   = 0;
      exp_stop   = 0;
      exp_ovf    = 0;
    end else begin
      exp_stop = i_abort;
      exp_ovf  = i_wr_en && (i_abort || exp_q.size() == DEPTH);
      if (i_abort) begin
        exp_q.delete();
        in_flight  = 0;
        start_pend = 0;
        gap_left   = 0;
      end else begin
        if (gap_left > 0) gap_left--;
        if (in_flight && (resp_done || man_done)) begin
          exp_cnt   = (exp_cnt + 1) % 65536;
          in_flight = 0;
          gap_left  = GAP_CYCLES;
        end
        if (start_pend) begin
          in_flight  = 1;
          start_pend = 0;
        end
        if (i_wr_en && exp_q.size() < DEPTH)
          exp_q.push_back('{data: i_wr_data, sel: i_wr_sel, idle: i_wr_idle});
      end
    end
  end

  // Monitor: pops the scoreboard on each start and checks status every cycle.
  initial forever begin
    word_t e;
    @(negedge clk);
    if (checking) begin
      if (o_start) begin
        check("start_while_active", 64'(in_flight || start_pend || gap_left > 0), 64'(0));
        if (exp_q.size() == 0) begin
          check("unexpected_start", 64'(o_start), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("o_data", 64'(o_data), 64'(e.data));
          check("o_sel_freq", 64'(o_sel_freq), 64'(e.sel));
          check("o_idle_mode", 64'(o_idle_mode), 64'(e.idle));
        end
        start_pend     = 1;
        n_starts++;
        last_start_cyc = cyc;
        last_data      = o_data;
        start_cycs.push_back(cyc);
        if (resp_en) resp_cnt = resp_rand ? int'($urandom_range(1, 8)) : resp_delay;
      end
      check("o_empty", 64'(o_empty), 64'(exp_q.size() == 0));
      check("o_full", 64'(o_full), 64'(exp_q.size() == DEPTH));
      check("o_word_cnt", 64'(o_word_cnt), 64'(exp_cnt));
      check("o_stop", 64'(o_stop), 64'(exp_stop));
      check("o_overflow", 64'(o_overflow), 64'(exp_ovf));
      check("o_busy", 64'(o_busy),
            64'(start_pend || in_flight || gap_left > 0 || exp_q.size() > 0));
    end
  end

  // Responder standing in for the serial stage: done tick N cycles after start.
  initial forever begin
    @(posedge clk);
    #1;
    resp_done = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) resp_done = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input logic s, input logic [1:0] m);
    i_wr_en   = 1'b1;
    i_wr_data = d;
    i_wr_sel  = s;
    i_wr_idle = m;
    step();
    i_wr_en = 1'b0;
  endtask

  task automatic push_rand();
    push(16'($urandom), 1'($urandom), 2'($urandom));
  endtask

  task automatic wait_starts(input int target, input int budget, input string name);
    int k = 0;
    while (n_starts < target && k < budget) begin
      step();
      k++;
    end
    check(name, 64'(n_starts >= target), 64'(1));
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while ((o_busy || exp_q.size() > 0) && k < budget) begin
      step();
      k++;
    end
    check(name, 64'(o_busy), 64'(0));
  endtask

  task automatic pulse_done();
    man_done = 1'b1;
    step();
    man_done = 1'b0;
  endtask

  initial begin
    int c0, base, d;
    logic [15:0] snap, held;

    repeat (3) step();
    checking = 1;
    check("rst_o_start", 64'(o_start), 64'(0));
    check("rst_o_data", 64'(o_data), 64'(0));
    check("rst_o_empty", 64'(o_empty), 64'(1));
    check("rst_o_busy", 64'(o_busy), 64'(0));
    rst = 1'b0;
    step();

    // Single word: start exactly two cycles after the push.
    resp_en = 1; resp_delay = 3; resp_rand = 0;
    c0 = cyc;
    push(16'hA5A5, 1'b1, 2'd0);
    wait_starts(1, 20, "t1_start_seen");
    check("t1_latency", 64'(last_start_cyc - c0), 64'(2));
    check("t1_data", 64'(o_data), 64'(16'hA5A5));
    check("t1_sel", 64'(o_sel_freq), 64'(1));
    repeat (12) step();
    check("t1_word_cnt", 64'(o_word_cnt), 64'(1));

    // Three words, done 20 cycles after each start, gap of 4.
    resp_delay = 20;
    base = n_starts;
    start_cycs.delete();
    repeat (3) push_rand();
    wait_starts(base + 3, 200, "t2_starts_seen");
    if (start_cycs.size() >= 3) begin
      check("t2_spacing_a", 64'(start_cycs[1] - start_cycs[0]), 64'(26));
      check("t2_spacing_b", 64'(start_cycs[2] - start_cycs[1]), 64'(26));
    end
    wait_idle(60, "t2_drain");
    check("t2_word_cnt", 64'(o_word_cnt), 64'(4));

    // Fill past depth while the first word is held in flight.
    resp_en = 0;
    base = n_starts;
    push_rand();
    wait_starts(base + 1, 20, "t3_first_start");
    for (int i = 0; i < 9; i++) begin
      push_rand();
      if (i == 6) check("t3_not_full_at_7", 64'(o_full), 64'(0));
      if (i == 7) check("t3_full_at_8", 64'(o_full), 64'(1));
      if (i == 8) check("t3_overflow_pulse", 64'(o_overflow), 64'(1));
    end
    step();
    check("t3_overflow_clears", 64'(o_overflow), 64'(0));
    resp_en = 1; resp_delay = 2;
    pulse_done();
    wait_starts(base + 9, 200, "t3_drain_starts");
    wait_idle(100, "t3_drain");
    repeat (10) step();
    check("t3_start_count", 64'(n_starts), 64'(base + 9));

    // Abort in BUSY with two queued, done tick in the same cycle.
    resp_en = 0;
    base = n_starts;
    snap = 16'(exp_cnt);
    repeat (3) push_rand();
    wait_starts(base + 1, 20, "t4_start");
    repeat (2) step();
    held = last_data;
    i_abort = 1'b1; man_done = 1'b1;
    step();
    i_abort = 1'b0; man_done = 1'b0;
    check("t4_stop", 64'(o_stop), 64'(1));
    check("t4_empty", 64'(o_empty), 64'(1));
    check("t4_cnt_held", 64'(o_word_cnt), 64'(snap));
    step();
    check("t4_stop_clears", 64'(o_stop), 64'(0));
    repeat (30) step();
    check("t4_no_more_start", 64'(n_starts), 64'(base + 1));
    check("t4_data_held", 64'(o_data), 64'(held));

    // Reset mid-BUSY with FIFO non-empty, then restart latency.
    resp_en = 1; resp_delay = 10;
    base = n_starts;
    repeat (3) push_rand();
    wait_starts(base + 1, 20, "t5_start");
    repeat (2) step();
    rst = 1'b1;
    step();
    check("t5_rst_empty", 64'(o_empty), 64'(1));
    check("t5_rst_data", 64'(o_data), 64'(0));
    check("t5_rst_cnt", 64'(o_word_cnt), 64'(0));
    check("t5_rst_busy", 64'(o_busy), 64'(0));
    check("t5_rst_idle_mode", 64'(o_idle_mode), 64'(0));
    rst = 1'b0;
    repeat (12) step();
    c0 = cyc;
    base = n_starts;
    push(16'h1234, 1'b0, 2'd3);
    wait_starts(base + 1, 20, "t5_restart");
    check("t5_latency", 64'(last_start_cyc - c0), 64'(2));
    wait_idle(60, "t5_drain");

    // Done tick in IDLE and GAP is ignored.
    resp_en = 0;
    snap = 16'(exp_cnt);
    base = n_starts;
    pulse_done();
    step();
    check("t6_idle_cnt", 64'(o_word_cnt), 64'(snap));
    check("t6_idle_busy", 64'(o_busy), 64'(0));
    repeat (2) push_rand();
    wait_starts(base + 1, 20, "t6_start");
    repeat (3) step();
    d = cyc;
    pulse_done();
    step();
    pulse_done();
    wait_starts(base + 2, 30, "t6_second_start");
    check("t6_gap_latency", 64'(last_start_cyc - d), 64'(GAP_CYCLES + 2));
    check("t6_cnt", 64'(o_word_cnt), 64'(16'(snap + 16'd1)));
    repeat (2) step();
    pulse_done();
    wait_idle(40, "t6_drain");

    // Random traffic with occasional aborts.
    resp_en = 1; resp_rand = 1;
    for (int i = 0; i < 500; i++) begin
      i_wr_en   = ($urandom_range(0, 2) == 0);
      i_wr_data = 16'($urandom);
      i_wr_sel  = 1'($urandom);
      i_wr_idle = 2'($urandom);
      i_abort   = ($urandom_range(0, 79) == 0);
      step();
    end
    i_wr_en = 1'b0;
    i_abort = 1'b0;
    wait_idle(400, "rand_drain");
    check("rand_word_cnt", 64'(o_word_cnt), 64'(exp_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish within 1 ms");
    $fatal(1, "timeout");
  end

endmodule
